float_n_to_recoded_float_n_serial: RTL and testbench

Sequential converter from standard IEEE-style floatN (`expSize`+`sigSize` bits) to the recoded floatN format (`size`+1 bits) consumed by the FPU datapath and by `recodedFloatNToFloatN`. It sits at the FPU operand-load boundary: it accepts one standard-format operand per handshake and emits its recoded equivalent. Zero, normal, infinity and NaN convert in one cycle. Subnormals are normalized by a one-bit-per-cycle shifter, which trades latency for area.

---
 rtl/float_n_to_recoded_float_n_serial_if.sv | 25 ++
 rtl/float_n_to_recoded_float_n_serial.sv | 133 +++++++++++++
 tb/tb_float_n_to_recoded_float_n_serial.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/float_n_to_recoded_float_n_serial_if.sv
// Operand/result handshake bundle for float_n_to_recoded_float_n_serial.
// Master drives operands and result acceptance; slave is the converter.
interface float_n_to_recoded_float_n_serial_if #(
    parameter int expSize = 8,
    parameter int sigSize = 24
);
    localparam int size = expSize + sigSize;

    logic            in_valid;
    logic            in_ready;
    logic [size-1:0] in;
    logic            out_valid;
    logic            out_ready;
    logic [size:0]   out;

    modport master (
        output in_valid, in, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, in, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/float_n_to_recoded_float_n_serial.sv
// Standard floatN -> recoded floatN converter; FAST_NORM_EN selects a one-cycle subnormal normalizer.
// Latency: 1 cycle for zero/normal/inf/NaN; subnormals take z+2 (serial) or 1 (FAST_NORM_EN).
// Backpressure: result held while out_ready=0; in_ready = idle | (done & out_ready).
module float_n_to_recoded_float_n_serial #(
    parameter int expSize = 8,
    parameter int sigSize = 24
) (
    input  logic clock,
    input  logic reset,
    float_n_to_recoded_float_n_serial_if.slave bus
);
    localparam int size   = expSize + sigSize;
    localparam int fractW = sigSize - 1;
    localparam int recW   = expSize + 1;
    localparam logic [recW-1:0] bias = recW'((1 << (expSize - 1)) + 1);

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    state_t              state, stateNext;
    logic [size:0]       outReg, outNext;
    logic                inReady, accept, inSub;
    logic [expSize-1:0]  inExp;
    logic [fractW-1:0]   inFract;

    // Zero, normal, infinity and NaN: fract passes through, only the exponent is remapped.
    function automatic logic [size:0] recodeSimple(input logic [size-1:0] f);
        logic [expSize-1:0] e;
        logic [fractW-1:0]  fr;
        logic [recW-1:0]    re;
        e  = f[size-2 -: expSize];
        fr = f[fractW-1:0];
        if (e == '0)
            re = '0;
        else if (&e)
            re = {2'b11, (fr != '0), {(expSize - 2){1'b0}}};
        else
            re = {1'b0, e} + bias;
        return {f[size-1], re, fr};
    endfunction

`ifdef FAST_NORM_EN
    function automatic logic [size:0] normalizeSub(input logic [size-1:0] f);
        logic [fractW-1:0] fr;
        logic [recW-1:0]   z;
        logic              found;
        fr    = f[fractW-1:0];
        z     = '0;
        found = 1'b0;
        for (int i = fractW - 1; i >= 0; i--) begin
            if (!found && fr[i]) begin
                found = 1'b1;
                z     = recW'(fractW - 1 - i);
            end
        end
        return {f[size-1], bias - z, fr << (z + recW'(1))};
    endfunction
`else
    logic [fractW-1:0] workFract, workFractNext;
    logic [recW-1:0]   recExp, recExpNext;
    logic              sign, signNext;
    logic              shiftOut;
`endif

    assign inExp   = bus.in[size-2 -: expSize];
    assign inFract = bus.in[fractW-1:0];
    assign inSub   = (inExp == '0) && (inFract != '0);
    assign inReady = (state == IDLE) || ((state == DONE) && bus.out_ready);
    assign accept  = bus.in_valid && inReady;

    assign bus.in_ready  = inReady;
    assign bus.out_valid = (state == DONE);
    assign bus.out       = outReg;

    always_comb begin
        stateNext = state;
        outNext   = outReg;
`ifndef FAST_NORM_EN
        workFractNext = workFract;
        recExpNext    = recExp;
        signNext      = sign;
        shiftOut      = 1'b0;
`endif
        case (state)
`ifndef FAST_NORM_EN
            NORM: begin
                // The first 1 shifted out is the hidden bit; what remains is the normalized fract.
                {shiftOut, workFractNext} = {workFract, 1'b0};
                recExpNext = recExp - recW'(1);
                if (shiftOut) begin
                    outNext   = {sign, recExpNext, workFractNext};
                    stateNext = DONE;
                end
            end
`endif
            DONE: if (bus.out_ready) stateNext = IDLE;
            default: ;
        endcase
        if (accept) begin
            if (inSub) begin
`ifdef FAST_NORM_EN
                outNext   = normalizeSub(bus.in);
                stateNext = DONE;
`else
                workFractNext = inFract;
                recExpNext    = bias + recW'(1);
                signNext      = bus.in[size-1];
                stateNext     = NORM;
`endif
            end else begin
                outNext   = recodeSimple(bus.in);
                stateNext = DONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            outReg <= '0;
        end else begin
            state  <= stateNext;
            outReg <= outNext;
        end
    end

`ifndef FAST_NORM_EN
    always_ff @(posedge clock) begin
        workFract <= workFractNext;
        recExp    <= recExpNext;
        sign      <= signNext;
    end
`endif
endmodule

// File: tb/tb_float_n_to_recoded_float_n_serial.sv
// Bench for float_n_to_recoded_float_n_serial: directed vectors, handshake corners, random sweep.
module tb_float_n_to_recoded_float_n_serial;
`ifdef FAST_NORM_EN
    localparam bit fastNorm = 1'b1;
`else
    localparam bit fastNorm = 1'b0;
`endif
    localparam int numRand = 3000;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    float_n_to_recoded_float_n_serial_if #(.expSize(8), .sigSize(24)) bus();

    float_n_to_recoded_float_n_serial #(.expSize(8), .sigSize(24)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [31:0] in;
        logic [32:0] expOut;
        int          z;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Forward model from the value definition: normalize by doubling until the hidden bit appears.
    function automatic logic [32:0] refRecode(input logic [31:0] f);
        int          e, re, z;
        longint      m;
        logic [22:0] fo;
        e = int'(f[30:23]);
        m = longint'(f[22:0]);
        z = 0;
        if (e == 0 && m == 0) begin
            re = 0; fo = '0;
        end else if (e == 255) begin
            re = (m != 0) ? 'h1C0 : 'h180; fo = f[22:0];
        end else if (e == 0) begin
            while (m < 64'd4194304) begin
                m = m * 2;
                z++;
            end
            re = 129 - z;
            fo = 23'((m * 2) % 64'd8388608);
        end else begin
            re = e + 129; fo = f[22:0];
        end
        return {f[31], 9'(re), fo};
    endfunction

    // Inverse (recodedFloatNToFloatN behaviour), used for the round-trip check.
    function automatic logic [31:0] refUnrecode(input logic [32:0] r);
        int          re, e;
        longint      m;
        logic [22:0] fo;
        re = int'(r[31:23]);
        m  = longint'(r[22:0]);
        case (r[31:29])
            3'b000:  begin e = 0;   fo = '0; end
            3'b110:  begin e = 255; fo = '0; end
            3'b111:  begin e = 255; fo = r[22:0]; end
            default: begin
                if (re >= 130) begin
                    e = re - 129; fo = r[22:0];
                end else begin
                    e = 0; fo = 23'((m + 64'd8388608) >> (130 - re));
                end
            end
        endcase
        return {r[32], 8'(e), fo};
    endfunction

    function automatic logic [31:0] randOp();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0: begin r[30:23] = 8'h00; r[22:0] = r[22:0] >> $urandom_range(0, 22); end
            1: begin r[30:23] = 8'hFF; if ($urandom_range(0, 1) == 1) r[22:0] = '0; end
            2: r[30:0] = '0;
            default: ;
        endcase
        return r;
    endfunction

    task automatic runOne(input string name, input logic [31:0] op, input logic [32:0] expOut,
                          input int lat);
        int n;
        bus.in_valid  = 1'b1;
        bus.in        = op;
        bus.out_ready = 1'b1;
        @(negedge clock);
        check({name, " in_ready"}, 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.in       = $urandom;
        n = 1;
        if (lat > 1) check({name, " in_ready in NORM"}, 64'(bus.in_ready), 64'd0);
        while (!bus.out_valid && n < 40) begin
            tick();
            n++;
        end
        check({name, " latency"}, 64'(n), 64'(lat));
        check({name, " out"}, 64'(bus.out), 64'(expOut));
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[12];
        logic [31:0] ops[4];
        logic [32:0] exps[4];
        logic [31:0] q[$];
        logic [31:0] pending, e;
        bit          have;
        int          lat, done, sent, cycles, spurious;

        vecs = '{
            '{32'h3F800000, 33'h080000000, -1},
            '{32'h80000000, 33'h100000000, -1},
            '{32'h7F800000, 33'h0C0000000, -1},
            '{32'h7FC00000, 33'h0E0400000, -1},
            '{32'hFF800000, 33'h1C0000000, -1},
            '{32'h00000000, 33'h000000000, -1},
            '{32'h00800000, 33'h041000000, -1},
            '{32'h7F7FFFFF, 33'h0BFFFFFFF, -1},
            '{32'h00400000, 33'h040800000,  0},
            '{32'h807FFFFF, 33'h140FFFFFE,  0},
            '{32'h00000300, 33'h03A400000, 13},
            '{32'h00000001, 33'h035800000, 22}
        };
        ops  = '{32'h3F800000, 32'h40000000, 32'hC0490FDB, 32'h00800000};
        exps = '{33'h080000000, 33'h080800000, 33'h180C90FDB, 33'h041000000};

        bus.in_valid  = 1'b0;
        bus.in        = '0;
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset out", 64'(bus.out), 64'd0);
        check("reset in_ready", 64'(bus.in_ready), 64'd1);

        foreach (vecs[i]) begin
            lat = (vecs[i].z < 0 || fastNorm) ? 1 : vecs[i].z + 2;
            runOne($sformatf("vec%0d", i), vecs[i].in, vecs[i].expOut, lat);
        end

        // Back-to-back normals at full rate.
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.in       = ops[k];
            @(negedge clock);
            check($sformatf("b2b%0d in_ready", k), 64'(bus.in_ready), 64'd1);
            tick();
            check($sformatf("b2b%0d out_valid", k), 64'(bus.out_valid), 64'd1);
            check($sformatf("b2b%0d out", k), 64'(bus.out), 64'(exps[k]));
        end
        bus.in_valid = 1'b0;
        tick();

        // Back-pressure: result held, next operand waits, accepted on release.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in        = 32'h3F800000;
        tick();
        bus.in = 32'h40000000;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            check($sformatf("bp%0d out_valid", c), 64'(bus.out_valid), 64'd1);
            check($sformatf("bp%0d out", c), 64'(bus.out), 64'h080000000);
            check($sformatf("bp%0d in_ready", c), 64'(bus.in_ready), 64'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        @(negedge clock);
        check("bp release in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        check("bp next out", 64'(bus.out), 64'h080800000);
        bus.in_valid = 1'b0;
        tick();

        // Reset while the smallest subnormal is in flight.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in        = 32'h00000001;
        tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset out_valid", 64'(bus.out_valid), 64'd0);
        check("midreset in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        spurious = 0;
        for (int c = 0; c < 30; c++) begin
            if (bus.out_valid) spurious++;
            tick();
        end
        check("midreset no stale result", 64'(spurious), 64'd0);

        // Random sweep with random stalls, scoreboarded in order.
        have   = 1'b0;
        done   = 0;
        sent   = 0;
        cycles = 0;
        while (done < numRand && cycles < 50000) begin
            if (!have && sent < numRand && $urandom_range(0, 7) != 0) begin
                pending = randOp();
                have    = 1'b1;
                sent++;
            end
            bus.in_valid  = have;
            bus.in        = have ? pending : $urandom;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL rand spurious output: got 0x%0h, expected none", bus.out);
                end else begin
                    e = q.pop_front();
                    check("rand out", 64'(bus.out), 64'(refRecode(e)));
                    check("rand roundtrip", 64'(refUnrecode(bus.out)), 64'(e));
                    done++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(pending);
                have = 1'b0;
            end
            tick();
            cycles++;
        end
        check("rand results drained", 64'(done), 64'(numRand));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
